// File: rtl/imem_arbiter_if.sv
// Fetch and loader request/response bundle shared with the instruction-memory arbiter.
// The arbiter takes the slave side; fetch unit and loader/debug master drive the master side.
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_ren;
  logic [ADDR_W-1:0] f_addr0;
  logic [ADDR_W-1:0] f_addr1;
  logic              f_stall;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata0;
  logic [DATA_W-1:0] f_rdata1;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  modport slave (
    input  f_ren, f_addr0, f_addr1, ld_req, ld_we, ld_addr, ld_wdata,
    output f_stall, f_rvalid, f_rdata0, f_rdata1, ld_gnt, ld_rvalid, ld_rdata
  );

  modport master (
    output f_ren, f_addr0, f_addr1, ld_req, ld_we, ld_addr, ld_wdata,
    input  f_stall, f_rvalid, f_rdata0, f_rdata1, ld_gnt, ld_rvalid, ld_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the dual-port instruction BRAM between fetch (priority) and a loader/debug master,
// bounding loader starvation with a wait counter and loader occupancy with a burst limit.
module imem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  imem_arbiter_if.slave     bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1
);
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT_C  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LIMIT_C = BURST_W'(BURST_MAX);

  typedef enum logic {OWN_FETCH = 1'b0, OWN_LOAD = 1'b1} owner_t;

  owner_t             owner_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [BURST_W-1:0] burst_cnt_r;
  logic               f_rvalid_r;
  logic               ld_rvalid_r;
  logic               ld_gnt_s;
  logic               f_stall_s;
  logic               f_acc_s;

  // Grant decision: fetch wins unless the loader has waited out MAX_WAIT or already owns the port.
  always_comb begin
    ld_gnt_s  = 1'b0;
    f_stall_s = 1'b1;
    if (!reset) begin
      ld_gnt_s  = 1'b0;
      f_stall_s = 1'b1;
    end else if (owner_r == OWN_LOAD) begin
      ld_gnt_s  = bus.ld_req && (burst_cnt_r < BURST_LIMIT_C);
      f_stall_s = bus.f_ren && ld_gnt_s;
    end else begin
      ld_gnt_s  = bus.ld_req && (!bus.f_ren || (wait_cnt_r == WAIT_LIMIT_C));
      f_stall_s = bus.f_ren && ld_gnt_s;
    end
    f_acc_s = bus.f_ren && !f_stall_s;
  end

  // BRAM port mux; idle cycles still present fetch addresses so they never toggle needlessly.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr0 = bus.f_addr0;
    mem_addr1 = bus.f_addr1;
    mem_wdata = bus.ld_wdata;
    if (ld_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = bus.ld_we;
      mem_addr0 = bus.ld_addr;
      mem_addr1 = bus.ld_addr;
    end else if (f_acc_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  // Ownership, starvation/burst counters and read-return flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_r     <= OWN_FETCH;
      wait_cnt_r  <= '0;
      burst_cnt_r <= '0;
      f_rvalid_r  <= 1'b0;
      ld_rvalid_r <= 1'b0;
    end else begin
      f_rvalid_r  <= f_acc_s;
      ld_rvalid_r <= ld_gnt_s && !bus.ld_we;
      case (owner_r)
        OWN_FETCH: begin
          if (ld_gnt_s) begin
            owner_r     <= OWN_LOAD;
            burst_cnt_r <= BURST_W'(1);
            wait_cnt_r  <= '0;
          end else if (bus.ld_req) begin
            if (wait_cnt_r != WAIT_LIMIT_C) begin
              wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
          end else begin
            wait_cnt_r <= '0;
          end
        end
        OWN_LOAD: begin
          // Loader releases on idle or burst exhaustion; fetch owns this very cycle.
          if (ld_gnt_s) begin
            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
          end else begin
            owner_r     <= OWN_FETCH;
            burst_cnt_r <= '0;
            wait_cnt_r  <= '0;
          end
        end
        default: begin
          owner_r     <= OWN_FETCH;
          burst_cnt_r <= '0;
          wait_cnt_r  <= '0;
        end
      endcase
    end
  end

  assign bus.f_stall   = f_stall_s;
  assign bus.ld_gnt    = ld_gnt_s;
  assign bus.f_rvalid  = f_rvalid_r;
  assign bus.ld_rvalid = ld_rvalid_r;
  assign bus.f_rdata0  = mem_rdata0;
  assign bus.f_rdata1  = mem_rdata1;
  assign bus.ld_rdata  = mem_rdata0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a behavioural arbitration/memory model predicts grants and
// read data; a separate monitor pops expected responses whenever read data is due.
module tb_imem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;
  localparam int BURST_MAX = 8;

  typedef struct {
    int          due;
    logic [31:0] d0;
    logic [31:0] d1;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_mem;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [DW-1:0] mem_wdata, mem_rdata0, mem_rdata1;
  logic [31:0]   bram [64];
  logic [31:0]   refmem [64];
  rsp_t          fq[$];
  rsp_t          lq[$];
  rsp_t          fr, lr;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            refused = 0;
  int            streak = 0;

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_wdata(mem_wdata), .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 0) return 32'h1111_1111;
    if (i == 1) return 32'h2222_2222;
    return (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  // Synchronous dual-port BRAM, one-cycle read latency, write on port 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_mem) begin
      for (int i = 0; i < 64; i++) bram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr0[7:2]] <= mem_wdata;
      mem_rdata0 <= bram[mem_addr0[7:2]];
      mem_rdata1 <= bram[mem_addr1[7:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict from the rules, compare combinational outputs, queue reads.
  task automatic step(input logic rst, input logic fren, input logic [31:0] a0, input logic [31:0] a1,
                      input logic lreq, input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
                      output logic gnt);
    logic stall, facc, en, we;
    @(posedge clk);
    #1;
    reset = rst; bus.f_ren = fren; bus.f_addr0 = a0; bus.f_addr1 = a1;
    bus.ld_req = lreq; bus.ld_we = lwe; bus.ld_addr = la; bus.ld_wdata = lwd;
    #2;
    if (!rst) begin
      gnt = 1'b0; stall = 1'b1;
      refused = 0; streak = 0;
    end else if (streak > 0) begin
      gnt = lreq && (streak < BURST_MAX);
      stall = fren && gnt;
      if (gnt) streak++;
      else begin streak = 0; refused = 0; end
    end else begin
      gnt = lreq && (!fren || refused >= MAX_WAIT);
      stall = fren && gnt;
      if (gnt) begin streak = 1; refused = 0; end
      else if (lreq) refused = (refused + 1 > MAX_WAIT) ? MAX_WAIT : refused + 1;
      else refused = 0;
    end
    facc = rst && fren && !stall;
    en = gnt || facc;
    we = gnt && lwe;
    chk("ld_gnt", {31'd0, bus.ld_gnt}, {31'd0, gnt});
    chk("f_stall", {31'd0, bus.f_stall}, {31'd0, stall});
    chk("mem_en", {31'd0, mem_en}, {31'd0, en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    if (facc) fq.push_back('{due: cyc + 1, d0: refmem[a0[7:2]], d1: refmem[a1[7:2]]});
    if (gnt && !lwe) lq.push_back('{due: cyc + 1, d0: refmem[la[7:2]], d1: 32'd0});
    if (gnt && lwe) refmem[la[7:2]] = lwd;
  endtask

  // Monitor: read data must appear exactly when due and never otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (fq.size() > 0 && fq[0].due == cyc) begin
        fr = fq.pop_front();
        chk("f_rvalid", {31'd0, bus.f_rvalid}, 32'd1);
        chk("f_rdata0", bus.f_rdata0, fr.d0);
        chk("f_rdata1", bus.f_rdata1, fr.d1);
      end else begin
        chk("f_rvalid_idle", {31'd0, bus.f_rvalid}, 32'd0);
      end
      if (lq.size() > 0 && lq[0].due == cyc) begin
        lr = lq.pop_front();
        chk("ld_rvalid", {31'd0, bus.ld_rvalid}, 32'd1);
        chk("ld_rdata", bus.ld_rdata, lr.d0);
      end else begin
        chk("ld_rvalid_idle", {31'd0, bus.ld_rvalid}, 32'd0);
      end
    end
  end

  initial begin
    logic        g;
    int          first;
    int          n;
    int          cycles;
    logic [31:0] addr;
    reset = 1'b0; load_mem = 1'b1;
    bus.f_ren = 1'b0; bus.f_addr0 = 32'd0; bus.f_addr1 = 32'd0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 32'd0; bus.ld_wdata = 32'd0;
    for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
    @(posedge clk);
    #1 load_mem = 1'b0;

    // Reset held with both masters requesting.
    repeat (2) step(1'b0, 1'b1, 32'h0, 32'h4, 1'b1, 1'b1, 32'h80, 32'h0, g);
    // Fetch only, words 0x00/0x04.
    repeat (2) step(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, g);

    // Starvation: loader must be granted on the fifth requesting cycle.
    first = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 32'h8, 32'hC, 1'b1, 1'b1, 32'hF0, 32'h5555_0000 + i, g);
      if (bus.ld_gnt && first < 0) first = i;
    end
    chk("starve_first_grant", first, 32'd4);
    repeat (2) step(1'b1, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, g);

    // Burst of 12 writes 0x40..0x6C against continuous fetch.
    addr = 32'h40; n = 0; cycles = 0;
    while (n < 12 && cycles < 60) begin
      step(1'b1, 1'b1, 32'h10, 32'h14, 1'b1, 1'b1, addr, 32'hC0DE_0000 + n, g);
      cycles++;
      if (g) begin n++; addr = addr + 32'd4; end
    end
    chk("burst_beats", n, 32'd12);
    step(1'b1, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, g);
    // Read the burst back through the loader.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h40 + 4 * i, 32'h0, g);
    step(1'b1, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, g);

    // Write then read the same word on consecutive beats.
    step(1'b1, 1'b0, 32'h0, 32'h4, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, g);
    step(1'b1, 1'b0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, g);
    step(1'b1, 1'b1, 32'h8, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, g);

    // Reset right after an accepted fetch, then confirm counters restarted.
    step(1'b1, 1'b1, 32'h0, 32'h4, 1'b1, 1'b0, 32'h20, 32'h0, g);
    repeat (2) step(1'b0, 1'b1, 32'h0, 32'h4, 1'b1, 1'b0, 32'h20, 32'h0, g);
    first = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 32'h18, 32'h1C, 1'b1, 1'b0, 32'h24, 32'h0, g);
      if (bus.ld_gnt && first < 0) first = i;
    end
    chk("post_reset_first_grant", first, 32'd4);

    // Randomised traffic with phases of varying loader pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic        r, fr_en, lq_en, lw;
      logic [31:0] ra0, ra1, rla;
      r     = ($urandom_range(0, 249) != 0);
      fr_en = ($urandom_range(0, 3) != 0);
      lq_en = ($urandom_range(0, 9) < ((i / 300) % 4) * 3 + 1);
      lw    = $urandom_range(0, 1) == 1;
      ra0   = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      ra1   = ra0 + 32'd4;
      rla   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      step(r, fr_en, ra0, ra1 & 32'hFC, lq_en, lw, rla, $urandom, g);
    end

    repeat (3) step(1'b1, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, g);
    chk("fetch_queue_empty", fq.size(), 32'd0);
    chk("load_queue_empty", lq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
